alu_seq: RTL

- Parametrised, multi-cycle successor to the processor's combinational ALU. Keeps the 3-bit SEL operation encoding and the zero flag.
- Adds a valid/ready handshake, a registered result, and iterative shift-add multiply and restoring divide. Divide also produces a remainder (HI) and a divide-by-zero flag.
- Sits in the EX stage. The control unit stalls the pipeline while in_ready is low.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_muldiv_iter.sv | 92 +++++++++
 rtl/alu_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation select codes and FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative engine shared by shift-add multiply and restoring divide.
// res_lo/res_hi show the value after the current step, so the final step's result can be registered directly.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] op_x,
  input  logic [WIDTH-1:0] op_y,
  output logic             last,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // reg_a: product accumulator / partial remainder
  // reg_b: shifting multiplicand / dividend-quotient
  // reg_c: shifting multiplier / divisor
  logic [WIDTH-1:0] reg_a, reg_b, reg_c;
  logic [WIDTH-1:0] nxt_a, nxt_b, nxt_c;
  logic [WIDTH:0]   shifted, diff;
  logic [CNT_W-1:0] cnt;
  logic             is_div;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // One multiply or divide step
  always_comb begin
    shifted = {reg_a, reg_b[WIDTH-1]};
    diff    = shifted - {1'b0, reg_c};
    nxt_a   = reg_a;
    nxt_b   = reg_b;
    nxt_c   = reg_c;
    if (is_div) begin
      if (!diff[WIDTH]) begin
        nxt_a = diff[WIDTH-1:0];
        nxt_b = {reg_b[WIDTH-2:0], 1'b1};
      end else begin
        nxt_a = shifted[WIDTH-1:0];
        nxt_b = {reg_b[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (reg_c[0]) begin
        nxt_a = reg_a + reg_b;
      end else begin
        nxt_a = reg_a;
      end
      nxt_b = {reg_b[WIDTH-2:0], 1'b0};
      nxt_c = {1'b0, reg_c[WIDTH-1:1]};
    end
  end

  // Result selection
  always_comb begin
    if (is_div) begin
      res_lo = nxt_b;
      res_hi = nxt_a;
    end else begin
      res_lo = nxt_a;
      res_hi = {WIDTH{1'b0}};
    end
  end

  // Operand load and iteration state; counter saturates at WIDTH-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_a  <= {WIDTH{1'b0}};
      reg_b  <= {WIDTH{1'b0}};
      reg_c  <= {WIDTH{1'b0}};
      cnt    <= {CNT_W{1'b0}};
      is_div <= 1'b0;
    end else if (load) begin
      reg_a  <= {WIDTH{1'b0}};
      reg_b  <= op_x;
      reg_c  <= op_y;
      cnt    <= {CNT_W{1'b0}};
      is_div <= div_mode;
    end else if (step) begin
      reg_a <= nxt_a;
      reg_b <= nxt_b;
      reg_c <= nxt_c;
      if (!last) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU with valid/ready handshake, registered results,
// iterative MUL/DIV and a divide-by-zero flag.
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [2:0]       SEL,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] HI,
  output logic             out_valid,
  output logic             Z_flag,
  output logic             dbz
);

  state_t           state, next_state;
  logic             accept, load_iter, single, div_zero, step, finish, last;
  logic [WIDTH-1:0] single_res, iter_lo, iter_hi;

  assign in_ready = (state == S_IDLE) || (state == S_DONE);
  assign accept   = start && in_ready;
  assign step     = (state == S_MUL) || (state == S_DIV);
  assign finish   = step && last;

  // Single-cycle datapath
  always_comb begin
    single_res = X;
    case (SEL)
      OP_ADD:  single_res = X + Y;
      OP_SUB:  single_res = X - Y;
      OP_AND:  single_res = X & Y;
      OP_OR:   single_res = X | Y;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(X) < $signed(Y))};
      OP_DIV:  single_res = {WIDTH{1'b1}};
      OP_NOP:  single_res = X;
      default: single_res = X;
    endcase
  end

  // Next-state and control decode
  always_comb begin
    next_state = state;
    load_iter  = 1'b0;
    single     = 1'b0;
    div_zero   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (SEL == OP_MUL) begin
            load_iter  = 1'b1;
            next_state = S_MUL;
          end else if ((SEL == OP_DIV) && (Y != {WIDTH{1'b0}})) begin
            load_iter  = 1'b1;
            next_state = S_DIV;
          end else begin
            single     = 1'b1;
            div_zero   = (SEL == OP_DIV);
            next_state = S_IDLE;
          end
        end else begin
          next_state = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (last) begin
          next_state = S_DONE;
        end else begin
          next_state = state;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Output registers: R/HI/flags only change when a result is presented
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      R         <= {WIDTH{1'b0}};
      HI        <= {WIDTH{1'b0}};
      Z_flag    <= 1'b0;
      dbz       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= single || finish;
      if (single) begin
        R      <= single_res;
        HI     <= div_zero ? X : {WIDTH{1'b0}};
        Z_flag <= (single_res == {WIDTH{1'b0}});
        dbz    <= div_zero;
      end else if (finish) begin
        R      <= iter_lo;
        HI     <= iter_hi;
        Z_flag <= (iter_lo == {WIDTH{1'b0}});
        dbz    <= 1'b0;
      end
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (load_iter),
    .step     (step),
    .div_mode (SEL == OP_DIV),
    .op_x     (X),
    .op_y     (Y),
    .last     (last),
    .res_lo   (iter_lo),
    .res_hi   (iter_hi)
  );

endmodule
